// File: rtl/kb_scan_ctrl.sv
// PS/2 scan-code decoder: synchronises the byte receiver's done level, strips E0/F0/E1 prefixes, queues events in a FWFT FIFO.
// Optional typematic-repeat suppression is enabled by defining KB_TYPEMATIC_FILTER_EN.
module kb_scan_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_done,
    input  logic [7:0] i_frame_data,
    input  logic       i_evt_ready,
    input  logic       i_clr_ovf,
    output logic       o_evt_valid,
    output logic [7:0] o_evt_code,
    output logic       o_evt_ext,
    output logic       o_evt_break,
    output logic       o_overflow,
    output logic [4:0] o_fifo_count
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      DEPTH    = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E0   = 3'd1,
        ST_F0   = 3'd2,
        ST_E0F0 = 3'd3,
        ST_SKIP = 3'd4
    } state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'h00, 8'hFF: is_ignored = 1'b1;
            default:                                  is_ignored = 1'b0;
        endcase
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        case (b)
            8'h12, 8'h59: is_fake_shift = 1'b1;
            default:      is_fake_shift = 1'b0;
        endcase
    endfunction

    logic          sync1_r, sync2_r, sync3_r;
    logic [1:0]    settle_cnt_r;
    logic          armed_r;
    logic          strobe_s;
    state_t        state_r;
    logic [2:0]    skip_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          push_r;
    logic [7:0]    push_code_r;
    logic          push_ext_r;
    logic          push_brk_r;
    logic          dup_s;
    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [4:0]    count_r;
    logic          overflow_r;
    logic          pop_s;
    logic          push_ok_s;
    logic [9:0]    head_s;

    // Done-level synchroniser; strobes stay disarmed until done has been seen low after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            sync3_r      <= 1'b0;
            settle_cnt_r <= 2'd0;
            armed_r      <= 1'b0;
        end else begin
            sync1_r <= i_frame_done;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            if (settle_cnt_r != 2'd2) begin
                settle_cnt_r <= settle_cnt_r + 2'd1;
            end
            if (settle_cnt_r == 2'd2 && !sync2_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign strobe_s = sync2_r & ~sync3_r & armed_r;

`ifdef KB_TYPEMATIC_FILTER_EN
    logic       held_valid_r;
    logic [7:0] held_code_r;
    logic       held_ext_r;

    // Remember the last make pushed until its break arrives
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            held_valid_r <= 1'b0;
            held_code_r  <= 8'h00;
            held_ext_r   <= 1'b0;
        end else if (push_r) begin
            if (!push_brk_r) begin
                held_valid_r <= 1'b1;
                held_code_r  <= push_code_r;
                held_ext_r   <= push_ext_r;
            end else if (held_valid_r && held_code_r == push_code_r && held_ext_r == push_ext_r) begin
                held_valid_r <= 1'b0;
            end
        end
    end

    assign dup_s = held_valid_r && (held_code_r == i_frame_data) && (held_ext_r == (state_r == ST_E0));
`else
    assign dup_s = 1'b0;
`endif

    // Prefix decoder with prefix timeout; emits at most one push per strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            skip_cnt_r  <= 3'd0;
            tmo_cnt_r   <= '0;
            push_r      <= 1'b0;
            push_code_r <= 8'h00;
            push_ext_r  <= 1'b0;
            push_brk_r  <= 1'b0;
        end else begin
            push_r <= 1'b0;
            if (strobe_s) begin
                tmo_cnt_r   <= '0;
                push_code_r <= i_frame_data;
                case (state_r)
                    ST_IDLE: begin
                        if (i_frame_data == 8'hE0) begin
                            state_r <= ST_E0;
                        end else if (i_frame_data == 8'hF0) begin
                            state_r <= ST_F0;
                        end else if (i_frame_data == 8'hE1) begin
                            state_r    <= ST_SKIP;
                            skip_cnt_r <= 3'd7;
                        end else if (!is_ignored(i_frame_data) && !dup_s) begin
                            push_r     <= 1'b1;
                            push_ext_r <= 1'b0;
                            push_brk_r <= 1'b0;
                        end
                    end
                    ST_E0: begin
                        if (i_frame_data == 8'hF0) begin
                            state_r <= ST_E0F0;
                        end else begin
                            state_r <= ST_IDLE;
                            if (!is_fake_shift(i_frame_data) && !dup_s) begin
                                push_r     <= 1'b1;
                                push_ext_r <= 1'b1;
                                push_brk_r <= 1'b0;
                            end
                        end
                    end
                    ST_F0: begin
                        state_r    <= ST_IDLE;
                        push_r     <= 1'b1;
                        push_ext_r <= 1'b0;
                        push_brk_r <= 1'b1;
                    end
                    ST_E0F0: begin
                        state_r <= ST_IDLE;
                        if (!is_fake_shift(i_frame_data)) begin
                            push_r     <= 1'b1;
                            push_ext_r <= 1'b1;
                            push_brk_r <= 1'b1;
                        end
                    end
                    ST_SKIP: begin
                        if (skip_cnt_r <= 3'd1) begin
                            skip_cnt_r <= 3'd0;
                            state_r    <= ST_IDLE;
                        end else begin
                            skip_cnt_r <= skip_cnt_r - 3'd1;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                if (tmo_cnt_r == TMO_LAST) begin
                    state_r    <= ST_IDLE;
                    tmo_cnt_r  <= '0;
                    skip_cnt_r <= 3'd0;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + 1'b1;
                end
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

    assign pop_s     = (count_r != 5'd0) && i_evt_ready;
    assign push_ok_s = push_r && ((count_r != DEPTH) || pop_s);

    // Event storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= {push_ext_r, push_brk_r, push_code_r};
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a set beats a clear)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= 5'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
            if (push_r && (count_r == DEPTH) && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (i_clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign o_evt_valid  = (count_r != 5'd0);
    assign o_evt_code   = head_s[7:0];
    assign o_evt_break  = head_s[8];
    assign o_evt_ext    = head_s[9];
    assign o_overflow   = overflow_r;
    assign o_fifo_count = count_r;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Self-checking bench for kb_scan_ctrl: directed scenarios plus randomized byte streams against a prefix-flag reference model.
module tb_kb_scan_ctrl;

    localparam int TMO   = 200;
    localparam int DEPTH = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_frame_done = 1'b0;
    logic [7:0] i_frame_data = 8'h00;
    logic       i_evt_ready = 1'b0;
    logic       i_clr_ovf = 1'b0;
    logic       o_evt_valid;
    logic [7:0] o_evt_code;
    logic       o_evt_ext;
    logic       o_evt_break;
    logic       o_overflow;
    logic [4:0] o_fifo_count;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    // reference model state: pending prefixes, skip bytes left, held make
    bit         m_ext, m_brk, m_held_v;
    int         m_skip;
    logic [8:0] m_held;
    bit         rnd_ready = 1'b0;

    kb_scan_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_done(i_frame_done),
        .i_frame_data(i_frame_data), .i_evt_ready(i_evt_ready), .i_clr_ovf(i_clr_ovf),
        .o_evt_valid(o_evt_valid), .o_evt_code(o_evt_code), .o_evt_ext(o_evt_ext),
        .o_evt_break(o_evt_break), .o_overflow(o_overflow), .o_fifo_count(o_fifo_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (i_rst_n && o_evt_valid && i_evt_ready) begin
            got_q.push_back({o_evt_ext, o_evt_break, o_evt_code});
        end
    end

    task automatic model_clear();
        m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    endtask

    task automatic model_emit(input logic [7:0] b, input bit ext, input bit brk);
`ifdef KB_TYPEMATIC_FILTER_EN
        if (!brk) begin
            if (m_held_v && m_held == {ext, b}) return;
            m_held_v = 1'b1;
            m_held   = {ext, b};
        end else if (m_held_v && m_held == {ext, b}) begin
            m_held_v = 1'b0;
        end
`endif
        exp_q.push_back({ext, brk, b});
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit plain;
        plain = !m_ext && !m_brk;
        if (m_skip > 0) begin
            m_skip--;
        end else if (plain && b == 8'hE1) begin
            m_skip = 7;
        end else if (plain && b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (plain && (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFC || b == 8'h00 || b == 8'hFF)) begin
                // acknowledge / self-test bytes carry no key
            end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
                // fake shift
            end else begin
                model_emit(b, m_ext, m_brk);
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_frame_data = b;
        i_frame_done = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 6) i_frame_done = 1'b0;
            if (rnd_ready) i_evt_ready = 1'($urandom_range(0, 1));
            @(negedge i_clk);
        end
        model_byte(b);
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);
    endtask

    task automatic check_events(input string name);
        int guard;
        i_evt_ready = 1'b1;
        guard = 0;
        while (o_fifo_count != 5'd0 && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        repeat (2) @(negedge i_clk);
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL %s drain: fifo_count=%0d still nonzero, required 0", name, o_fifo_count);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s event count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s event %0d: got {ext,brk,code}=%h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b required 0", o_evt_valid); end
        checks++; if (o_evt_code !== 8'h00) begin errors++; $display("FAIL reset code: got %h required 00", o_evt_code); end
        checks++; if ({o_evt_ext, o_evt_break} !== 2'b00) begin errors++; $display("FAIL reset ext/brk: got %b required 00", {o_evt_ext, o_evt_break}); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b required 0", o_overflow); end
        checks++; if (o_fifo_count !== 5'd0) begin errors++; $display("FAIL reset count: got %0d required 0", o_fifo_count); end
        apply_reset();
        model_clear();
        m_held_v = 1'b0;
    endtask

    task automatic test_make_break();
        i_evt_ready = 1'b1;
        @(negedge i_clk);
        i_frame_data = 8'h1C;
        i_frame_done = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL latency edge3: valid=%b required 0", o_evt_valid); end
        @(posedge i_clk);
        #1;
        checks++; if (o_evt_valid !== 1'b1) begin errors++; $display("FAIL latency edge4: valid=%b required 1", o_evt_valid); end
        repeat (4) @(negedge i_clk);
        i_frame_done = 1'b0;
        repeat (8) @(negedge i_clk);
        model_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_events("make_break");
    endtask

    task automatic test_extended();
        logic [7:0] seq [7] = '{8'hE0, 8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        foreach (seq[i]) send_byte(seq[i]);
        check_events("extended");
    endtask

    task automatic test_pause();
        logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        foreach (seq[i]) send_byte(seq[i]);
        check_events("pause_skip");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        i_evt_ready = 1'b0;
        foreach (codes[i]) send_byte(codes[i]);
        void'(exp_q.pop_back());  // ninth event is dropped by the full FIFO
        checks++; if (o_fifo_count !== 5'd8) begin errors++; $display("FAIL overflow count: got %0d required 8", o_fifo_count); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow flag: got %b required 1", o_overflow); end
        @(negedge i_clk); i_clr_ovf = 1'b1;
        @(negedge i_clk); i_clr_ovf = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL overflow clear: got %b required 0", o_overflow); end
        // push into a full FIFO in the same cycle as a pop
        i_frame_data = 8'h4B;
        i_frame_done = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_evt_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_evt_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        i_frame_done = 1'b0;
        repeat (8) @(negedge i_clk);
        model_byte(8'h4B);
        checks++; if (o_fifo_count !== 5'd8) begin errors++; $display("FAIL full push+pop count: got %0d required 8", o_fifo_count); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL full push+pop overflow: got %b required 0", o_overflow); end
        check_events("overflow");
    endtask

    task automatic test_timeout();
        send_byte(8'hF0);
        repeat (TMO + 20) @(negedge i_clk);
        model_clear();
        send_byte(8'h1C);
        checks++; if (exp_q.size() != 1 || exp_q[0] !== 10'h01C) begin errors++; $display("FAIL timeout model: %0d events", exp_q.size()); end
        check_events("timeout");
    endtask

    task automatic test_typematic();
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        int n_expected;
`ifdef KB_TYPEMATIC_FILTER_EN
        n_expected = 3;
`else
        n_expected = 5;
`endif
        foreach (seq[i]) send_byte(seq[i]);
        checks++;
        if (exp_q.size() != n_expected) begin
            errors++;
            $display("FAIL typematic model count: got %0d required %0d", exp_q.size(), n_expected);
        end
        check_events("typematic");
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_events("typematic_release");
    endtask

    task automatic test_random();
        logic [7:0] tbl [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'h12, 8'h59, 8'h00,
                                 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0};
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_byte(tbl[$urandom_range(0, 11)]);
        end
        rnd_ready = 1'b0;
        repeat (TMO + 20) @(negedge i_clk);
        model_clear();
        check_events("random");
    endtask

    task automatic test_back_to_back_reset();
        i_evt_ready = 1'b0;
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'h2B);
        send_byte(8'hE0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_fifo_count !== 5'd0) begin errors++; $display("FAIL mid reset count: got %0d required 0", o_fifo_count); end
        checks++; if (o_evt_valid !== 1'b0) begin errors++; $display("FAIL mid reset valid: got %b required 0", o_evt_valid); end
        i_frame_data = 8'h33;
        i_frame_done = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);
        checks++; if (o_fifo_count !== 5'd0) begin errors++; $display("FAIL done high at release: count=%0d required 0", o_fifo_count); end
        i_frame_done = 1'b0;
        repeat (6) @(negedge i_clk);
        exp_q.delete();
        got_q.delete();
        model_clear();
        m_held_v = 1'b0;
        send_byte(8'h1C);
        check_events("after_reset");
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_overflow();
        test_timeout();
        test_typematic();
        test_random();
        test_back_to_back_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kb_scan_ctrl.md
KB_SCAN_CTRL -- requirements
Module: kb_scan_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: event FIFO depth; power of two, 4..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000: i_clk cycles a prefix state may wait for its next byte.
REQ-003 Port i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port i_frame_done  input  1  byte-receiver done level, asynchronous to i_clk, high for at least one PS/2 clock period per byte.
REQ-006 Port i_frame_data  input  8  received byte; stable while i_frame_done is high.
REQ-007 Port i_evt_ready  input  1  consumer accepts the head event.
REQ-008 Port i_clr_ovf  input  1  clears o_overflow.
REQ-009 Port o_evt_valid  output  1  FIFO non-empty; head event presented.
REQ-010 Port o_evt_code  output  8  head event scan code, without prefixes.
REQ-011 Port o_evt_ext  output  1  head event carried the E0 prefix.
REQ-012 Port o_evt_break  output  1  head event is a release (F0 prefix).
REQ-013 Port o_overflow  output  1  sticky: an event was dropped.
REQ-014 Port o_fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-015 i_frame_done SHALL pass through a 2-flop synchronizer; a byte strobe SHALL fire for one cycle on the synchronized rising edge, and i_frame_data SHALL be captured in that cycle.
REQ-016 Decoder FSM states: IDLE, E0, F0, E0F0, SKIP.
REQ-017 IDLE: E0->E0; F0->F0; E1->SKIP with skip counter 7; FA, AA, EE, FC, 00, FF->discarded, stay in IDLE; any other byte->push {code, ext=0, brk=0}, stay in IDLE.
REQ-018 E0: F0->E0F0; 12 or 59 (fake shift)->discard, go to IDLE; other->push {code, ext=1, brk=0}, go to IDLE.
REQ-019 F0: any byte->push {code, ext=0, brk=1}, go to IDLE. E0F0: 12 or 59->discard, go to IDLE; other->push {code, ext=1, brk=1}, go to IDLE.
REQ-020 SKIP: each strobe decrements the counter; leave for IDLE on the strobe that brings it to 0; no events are pushed.
REQ-021 Timeout counter SHALL reset on every strobe and count while in E0, F0, E0F0 or SKIP; on reaching TIMEOUT_CYCLES, the FSM SHALL go to IDLE with no push.
REQ-022 Latency: o_evt_valid SHALL rise exactly 4 i_clk edges after i_frame_done rises, when the FIFO is empty and i_frame_done meets setup at the first flop.
REQ-023 FIFO SHALL be first-word-fall-through; pop occurs on o_evt_valid && i_evt_ready; i_evt_ready while empty has no effect.
REQ-024 Push while full without a pop SHALL drop the new event and set o_overflow; push and pop in the same cycle while full SHALL accept the push.
REQ-025 o_overflow SHALL clear on i_clr_ovf; a same-cycle set SHALL win over the clear.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 While i_rst_n is low: FSM=IDLE, synchronizer flops=0, timeout and skip counters=0, FIFO empty, o_evt_valid=0, o_evt_code=00, o_evt_ext=0, o_evt_break=0, o_overflow=0, o_fifo_count=0.
REQ-028 Reset asserted mid-sequence (any state, FIFO non-empty) SHALL discard all partial prefixes and queued events.
REQ-029 If i_frame_done is already high when reset releases, it SHALL NOT produce a strobe.

Configuration
REQ-030 Macro KB_TYPEMATIC_FILTER_EN defined: a make event whose {code, ext} equals the last pushed make while that key remains unreleased SHALL be discarded; a break of that key clears the held record.
REQ-031 Macro KB_TYPEMATIC_FILTER_EN undefined: every make, including typematic repeats, SHALL be pushed; the held record logic SHALL not exist.

Verification
REQ-032 Bytes 1C, F0, 1C with i_evt_ready=1 -> two events: {1C,ext0,brk0} then {1C,ext0,brk1}; first event on o_evt_valid 4 cycles after the first done edge.
REQ-033 Bytes E0, 12, E0, 75, E0, F0, 75 -> events {75,ext1,brk0} then {75,ext1,brk1}; fake-shift 12 produces no event.
REQ-034 Byte E1 followed by 14, 77, E1, F0, 14, F0, 77, then 1C -> only {1C,0,0}.
REQ-035 i_evt_ready=0, 9 distinct makes, FIFO_DEPTH=8 -> o_fifo_count=8, o_overflow=1, the 9th event lost; i_clr_ovf pulse -> o_overflow=0.
REQ-036 Byte F0 then idle for TIMEOUT_CYCLES, then byte 1C -> event {1C,0,0} (make, not break).
REQ-037 With KB_TYPEMATIC_FILTER_EN defined: bytes 1C, 1C, 1C, F0, 1C, 1C -> events make, break, make; with the macro undefined -> 5 events.
